// File: rtl/float_gp02_pkg.sv
// Shared constants and types for the GP02 8-bit float multiplier (format 1|4|3, bias 7).
package float_gp02_pkg;

    localparam int unsigned NB_MANT = 3;
    localparam int unsigned NB_EXP  = 4;
    localparam int unsigned BIAS    = 7;
    localparam int unsigned NB_PROD = 2 * (NB_MANT + 1);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/multiplicador_mantisa_if.sv
// Operand and result handshake bundle of the mantissa multiplier stage.
interface multiplicador_mantisa_if #(
    parameter int unsigned NB_MANT = float_gp02_pkg::NB_MANT,
    parameter int unsigned NB_EXP  = float_gp02_pkg::NB_EXP
);

    logic                      i_valid;
    logic                      o_ready;
    logic                      i_signo_1;
    logic                      i_signo_2;
    logic [NB_MANT-1:0]        i_mantisa_1;
    logic [NB_MANT-1:0]        i_mantisa_2;
    logic [NB_EXP-1:0]         i_exponente;
    logic                      o_valid;
    logic                      i_ready;
    logic [NB_EXP+NB_MANT:0]   o_resultado;
    logic                      o_overflow;

    // Block-side view: operands and downstream ready come in, results go out.
    modport slave (
        input  i_valid,
        input  i_signo_1,
        input  i_signo_2,
        input  i_mantisa_1,
        input  i_mantisa_2,
        input  i_exponente,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_resultado,
        output o_overflow
    );

    modport master (
        output i_valid,
        output i_signo_1,
        output i_signo_2,
        output i_mantisa_1,
        output i_mantisa_2,
        output i_exponente,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_resultado,
        input  o_overflow
    );

endinterface

// File: rtl/multiplicador_mantisa_normalizador.sv
// Combinational normalization: picks mantissa from the product, bumps exponent, saturates.
module multiplicador_mantisa_normalizador #(
    parameter int unsigned NB_MANT = 3,
    parameter int unsigned NB_EXP  = 4
) (
    input  logic [2*(NB_MANT+1)-1:0] i_producto,
    input  logic [NB_EXP-1:0]        i_exponente,
    output logic [NB_MANT-1:0]       o_mantisa,
    output logic [NB_EXP-1:0]        o_exponente,
    output logic                     o_overflow
);

    localparam int unsigned NB_PROD = 2 * (NB_MANT + 1);
    localparam int unsigned MSB     = NB_PROD - 1;

    logic               w_incremento;
    logic [NB_EXP:0]    w_exp_ext;
    logic [NB_MANT-1:0] w_mant_sel;
    logic               w_unused;

    // Product of two values in [1,2) lies in [1,4): MSB set means it is >= 2.
    assign w_incremento = i_producto[MSB];
    assign w_exp_ext    = {1'b0, i_exponente} + (NB_EXP+1)'(w_incremento);
    assign w_mant_sel   = w_incremento ? i_producto[MSB-1 -: NB_MANT]
                                       : i_producto[MSB-2 -: NB_MANT];

    // Bits below the kept mantissa are truncated.
    assign w_unused = ^i_producto[MSB-NB_MANT-2:0];

    always_comb begin
        o_overflow  = w_exp_ext[NB_EXP];
        o_exponente = w_exp_ext[NB_EXP-1:0];
        o_mantisa   = w_mant_sel;
        if (w_exp_ext[NB_EXP]) begin
            o_exponente = '1;
            o_mantisa   = '1;
        end
    end

endmodule

// File: rtl/multiplicador_mantisa.sv
// Sequential shift-add mantissa multiplier with normalization and valid/ready handshakes.
module multiplicador_mantisa
    import float_gp02_pkg::*;
#(
    parameter int unsigned NB_MANT = float_gp02_pkg::NB_MANT,
    parameter int unsigned NB_EXP  = float_gp02_pkg::NB_EXP
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    multiplicador_mantisa_if.slave  if_bus
);

    localparam int unsigned NB_OPER = NB_MANT + 1;
    localparam int unsigned NB_ACC  = 2 * NB_OPER;
    localparam int unsigned NB_CNTR = (NB_OPER > 1) ? $clog2(NB_OPER) : 1;
    localparam int unsigned NB_OUT  = 1 + NB_EXP + NB_MANT;

    localparam logic [NB_CNTR-1:0] CNT_LAST = NB_CNTR'(NB_MANT);

    state_t               r_state;
    state_t               w_state_next;

    logic [NB_ACC-1:0]    r_multiplicando;
    logic [NB_OPER-1:0]   r_multiplicador;
    logic [NB_ACC-1:0]    r_acc;
    logic [NB_CNTR-1:0]   r_cnt;
    logic                 r_signo;
    logic [NB_EXP-1:0]    r_exp;
    logic [NB_OUT-1:0]    r_resultado;
    logic                 r_overflow;

    logic                 w_accept;
    logic [NB_MANT-1:0]   w_norm_mant;
    logic [NB_EXP-1:0]    w_norm_exp;
    logic                 w_norm_ovf;

    assign w_accept = (r_state == IDLE) && if_bus.i_valid;

    //------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (if_bus.i_valid) begin
                    w_state_next = MULT;
                end
            end
            MULT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = NORM;
                end
            end
            NORM: begin
                w_state_next = DONE;
            end
            DONE: begin
                if (if_bus.i_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Shift-add datapath
    //------------------------------------------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_multiplicando <= '0;
            r_multiplicador <= '0;
            r_acc           <= '0;
            r_cnt           <= '0;
        end else if (w_accept) begin
            r_multiplicando <= {{(NB_ACC-NB_OPER){1'b0}}, 1'b1, if_bus.i_mantisa_1};
            r_multiplicador <= {1'b1, if_bus.i_mantisa_2};
            r_acc           <= '0;
            r_cnt           <= '0;
        end else if (r_state == MULT) begin
            if (r_multiplicador[0]) begin
                r_acc <= r_acc + r_multiplicando;
            end
            r_multiplicando <= r_multiplicando << 1;
            r_multiplicador <= r_multiplicador >> 1;
            r_cnt           <= r_cnt + NB_CNTR'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_signo <= 1'b0;
            r_exp   <= '0;
        end else if (w_accept) begin
            r_signo <= if_bus.i_signo_1 ^ if_bus.i_signo_2;
            r_exp   <= if_bus.i_exponente;
        end
    end

    //------------------------------------------------------------------
    // Normalization and result register
    //------------------------------------------------------------------
    multiplicador_mantisa_normalizador #(
        .NB_MANT (NB_MANT),
        .NB_EXP  (NB_EXP)
    ) u_normalizador (
        .i_producto  (r_acc),
        .i_exponente (r_exp),
        .o_mantisa   (w_norm_mant),
        .o_exponente (w_norm_exp),
        .o_overflow  (w_norm_ovf)
    );

    // Result is written only in NORM and otherwise keeps the last value.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_resultado <= '0;
            r_overflow  <= 1'b0;
        end else if (r_state == NORM) begin
            r_resultado <= {r_signo, w_norm_exp, w_norm_mant};
            r_overflow  <= w_norm_ovf;
        end
    end

    assign if_bus.o_ready     = (r_state == IDLE);
    assign if_bus.o_valid     = (r_state == DONE);
    assign if_bus.o_resultado = r_resultado;
    assign if_bus.o_overflow  = r_overflow;

endmodule

// File: tb/tb_multiplicador_mantisa.sv
// Directed self-checking bench for multiplicador_mantisa with hand-computed results.
module tb_multiplicador_mantisa;

    typedef struct {
        logic       s1;
        logic       s2;
        logic [2:0] m1;
        logic [2:0] m2;
        logic [3:0] e;
        logic [7:0] res;
        logic       ovf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    vec_t vecs [8];

    multiplicador_mantisa_if u_if ();

    multiplicador_mantisa u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .if_bus  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_ops(input vec_t v);
        u_if.i_signo_1   = v.s1;
        u_if.i_signo_2   = v.s2;
        u_if.i_mantisa_1 = v.m1;
        u_if.i_mantisa_2 = v.m2;
        u_if.i_exponente = v.e;
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic start_op(input string tag, input vec_t v);
        @(negedge clk);
        chk({tag, "_ready_idle"}, u_if.o_ready, 1);
        drive_ops(v);
        u_if.i_valid = 1'b1;
        @(negedge clk);
        u_if.i_valid = 1'b0;
    endtask

    // Counts rising edges from (and including) the accept edge until o_valid is seen.
    task automatic wait_valid(input string tag);
        int lat;
        lat = 1;
        while (u_if.o_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 6);
    endtask

    task automatic run_op(input string tag, input vec_t v);
        u_if.i_ready = 1'b1;
        start_op(tag, v);
        wait_valid(tag);
        chk({tag, "_result"}, u_if.o_resultado, v.res);
        chk({tag, "_overflow"}, u_if.o_overflow, v.ovf);
        chk({tag, "_ready_busy"}, u_if.o_ready, 0);
        @(negedge clk);
        chk({tag, "_valid_drop"}, u_if.o_valid, 0);
        chk({tag, "_ready_back"}, u_if.o_ready, 1);
        chk({tag, "_result_hold"}, u_if.o_resultado, v.res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        //            s1    s2    m1      m2      e        res    ovf
        vecs[0] = '{1'b0, 1'b0, 3'b000, 3'b000, 4'b0111, 8'h38, 1'b0};  // 1.0 x 1.0
        vecs[1] = '{1'b0, 1'b0, 3'b100, 3'b100, 4'b0111, 8'h41, 1'b0};  // 1.5 x 1.5
        vecs[2] = '{1'b0, 1'b0, 3'b100, 3'b100, 4'b1111, 8'h7F, 1'b1};  // overflow
        vecs[3] = '{1'b1, 1'b0, 3'b000, 3'b000, 4'b0111, 8'hB8, 1'b0};  // negative
        vecs[4] = '{1'b0, 1'b0, 3'b111, 3'b111, 4'b0111, 8'h46, 1'b0};  // 225 -> 1110_0001
        vecs[5] = '{1'b0, 1'b0, 3'b010, 3'b011, 4'b0101, 8'h2D, 1'b0};  // 110 -> 0110_1110
        vecs[6] = '{1'b1, 1'b1, 3'b000, 3'b000, 4'b1111, 8'h78, 1'b0};  // max exp, no bump
        vecs[7] = '{1'b0, 1'b1, 3'b011, 3'b100, 4'b1111, 8'hFF, 1'b1};  // neg saturate

        rst          = 1'b1;
        u_if.i_valid = 1'b0;
        u_if.i_ready = 1'b0;
        drive_ops(vecs[0]);
        #12;
        chk("rst_ready", u_if.o_ready, 1);
        chk("rst_valid", u_if.o_valid, 0);
        chk("rst_result", u_if.o_resultado, 0);
        chk("rst_overflow", u_if.o_overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: hold DONE for 5 cycles while offering a new operation.
        u_if.i_ready = 1'b0;
        start_op("bp", vecs[1]);
        wait_valid("bp");
        drive_ops(vecs[7]);
        u_if.i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", i), u_if.o_valid, 1);
            chk($sformatf("bp_result_%0d", i), u_if.o_resultado, 8'h41);
            chk($sformatf("bp_ready_%0d", i), u_if.o_ready, 0);
        end
        u_if.i_valid = 1'b0;
        u_if.i_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", u_if.o_valid, 0);
        chk("bp_release_ready", u_if.o_ready, 1);
        run_op("after_bp", vecs[4]);

        // Asynchronous reset while multiplying.
        start_op("rst_mid", vecs[2]);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_ready", u_if.o_ready, 1);
        chk("rst_mid_valid", u_if.o_valid, 0);
        chk("rst_mid_result", u_if.o_resultado, 0);
        chk("rst_mid_overflow", u_if.o_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
